// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   fetch_entry_t : one buffered {pc, instr} pair as handed to decode
//   align_word    : clears the byte-offset bits of an address
package fetch_pkg;

    localparam int          WORD_W           = 32;
    localparam int          INSTR_BYTES      = 4;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [WORD_W-1:0] align_word(input logic [WORD_W-1:0] addr);
        return {addr[WORD_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer of fetched {pc, instr} entries.
// Ports:
//   clk, rst_n     : clock, synchronous active-low reset
//   flush_i        : discard all entries (beats push and pop)
//   push_i         : write push_data_i at the tail
//   push_data_i    : entry to write
//   pop_i          : drop the head entry
//   count_o        : current occupancy
//   head_o         : head entry, all zeros when empty
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  fetch_entry_t     push_data_i,
    input  logic             pop_i,
    output logic [CNT_W-1:0] count_o,
    output fetch_entry_t     head_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) return '0;
        return p + PTR_W'(1);
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = next_ptr(wr_ptr_q);
            if (pop_i)  rd_ptr_d = next_ptr(rd_ptr_q);
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; count_q alone decides what is visible.
    always_ff @(posedge clk) begin
        if (rst_n && !flush_i && push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign count_o = count_q;
    assign head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, issues reads to a 1-cycle-latency
// synchronous instruction memory and buffers responses for decode.
// Ports:
//   clk, rst_n                 : clock, synchronous active-low reset
//   imemReq, imemAddr          : memory read request and word address
//   imemRdata                  : read data, one cycle after imemReq
//   redirectValid/Target       : PC change from decode (flushes wrong path)
//   instrValid, instrReady     : handshake towards decode
//   instr, pc                  : buffered instruction and its address
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic [31:0] imemRdata,
    input  logic        redirectValid,
    input  logic [31:0] redirectTarget,
    output logic        instrValid,
    input  logic        instrReady,
    output logic [31:0] instr,
    output logic [31:0] pc
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic             inflight_q, inflight_d;
    logic [31:0]      inflight_pc_q, inflight_pc_d;

    logic [CNT_W-1:0] fifo_count;
    fetch_entry_t     fifo_head;
    fetch_entry_t     push_entry;
    logic             pop;
    logic             push;
    logic [CNT_W:0]   occ_after_pop;

    // A redirect voids both the pop and the arriving response.
    assign pop  = instrValid && instrReady && !redirectValid;
    assign push = inflight_q && !redirectValid;

    // Slots committed once this cycle's pop retires; counting the in-flight
    // request reserves its FIFO slot before the data arrives.
    assign occ_after_pop = {1'b0, fifo_count}
                         + {{CNT_W{1'b0}}, inflight_q}
                         - {{CNT_W{1'b0}}, pop};

    assign imemReq  = rst_n && !redirectValid
                   && (occ_after_pop < (CNT_W + 1)'(FIFO_DEPTH));
    assign imemAddr = fetch_pc_q;

    assign push_entry.pc    = inflight_pc_q;
    assign push_entry.instr = imemRdata;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = imemReq;
        if (redirectValid) begin
            fetch_pc_d = align_word(redirectTarget);
        end else if (imemReq) begin
            fetch_pc_d    = fetch_pc_q + 32'(INSTR_BYTES);
            inflight_pc_d = fetch_pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q    <= align_word(RESET_PC);
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (redirectValid),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .count_o     (fifo_count),
        .head_o      (fifo_head)
    );

    assign instrValid = (fifo_count != '0);
    assign instr      = instrValid ? fifo_head.instr : NOP_INSTR;
    assign pc         = instrValid ? fifo_head.pc    : 32'h0000_0000;

endmodule
